// File: rtl/mppt_po_controller_if.sv
// ============================================================================
// Module   : mppt_po_controller_if
// Brief    : Enable, ADC sample handshake and duty/status bundle of the tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mppt_po_controller_if #(
    parameter int DUTY_W = 8
) ();
    logic              en;
    logic              sample_req;
    logic              sample_valid;
    logic [7:0]        v_in;
    logic [7:0]        i_in;
    logic [DUTY_W-1:0] duty;
    logic              duty_update;
    logic              dir;
    logic [15:0]       power;
    logic              busy;

    // master = the tracker itself, slave = converter/ADC side driving it
    modport master (
        input  en, sample_valid, v_in, i_in,
        output sample_req, duty, duty_update, dir, power, busy
    );

    modport slave (
        output en, sample_valid, v_in, i_in,
        input  sample_req, duty, duty_update, dir, power, busy
    );
endinterface

`default_nettype wire

// File: rtl/mppt_po_controller.sv
// ============================================================================
// Module   : mppt_po_controller
// Brief    : Perturb-and-observe MPPT: settle, sample V/I, compare power, step duty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mppt_po_controller #(
    parameter int DUTY_W        = 8,
    parameter int STEP          = 4,
    parameter int DUTY_MIN      = 16,
    parameter int DUTY_MAX      = 240,
    parameter int DUTY_INIT     = 128,
    parameter int SETTLE_CYCLES = 1000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mppt_po_controller_if.master    bus
);

    localparam int                c_cnt_w      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_ld = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [DUTY_W:0]   c_step       = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0]   c_min        = (DUTY_W+1)'(DUTY_MIN);
    localparam logic [DUTY_W:0]   c_max        = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DUTY_W:0]   c_dn_floor   = (DUTY_W+1)'(DUTY_MIN + STEP);
    localparam logic [DUTY_W-1:0] c_init       = DUTY_W'(DUTY_INIT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_SAMPLE  = 3'd2,
        S_COMPUTE = 3'd3,
        S_UPDATE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [7:0]           r_v;
    logic [7:0]           r_i;
    logic [15:0]          r_p_prev;
    logic                 r_first;
    logic [DUTY_W-1:0]    r_duty;
    logic                 r_dir;
    logic                 r_upd;
    logic [15:0]          r_power;
    logic                 r_req;
    logic                 r_busy;

    logic [15:0]          w_prod;
    logic [DUTY_W:0]      w_up;
    logic [DUTY_W:0]      w_duty_next;
    logic                 w_at_limit;

    assign w_prod = 16'(r_v) * 16'(r_i);

    // One extra bit so duty+STEP never wraps before the clamp is applied
    always_comb begin
        w_up        = {1'b0, r_duty} + c_step;
        w_duty_next = {1'b0, r_duty};
        w_at_limit  = 1'b0;
        if (r_dir) begin
            w_duty_next = (w_up > c_max) ? c_max : w_up;
            w_at_limit  = (w_duty_next == c_max);
        end else begin
            w_duty_next = ({1'b0, r_duty} >= c_dn_floor) ? ({1'b0, r_duty} - c_step) : c_min;
            w_at_limit  = (w_duty_next == c_min);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_v      <= '0;
            r_i      <= '0;
            r_p_prev <= '0;
            r_first  <= 1'b1;
            r_duty   <= c_init;
            r_dir    <= 1'b1;
            r_upd    <= 1'b0;
            r_power  <= '0;
            r_req    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (!bus.en && (r_state != S_IDLE)) begin
                // Abort keeps duty/dir; the next run restarts as a first sample
                r_state <= S_IDLE;
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
                r_first <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_first <= 1'b1;
                        if (bus.en) begin
                            r_state <= S_SETTLE;
                            r_cnt   <= c_settle_ld;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= S_SAMPLE;
                            r_req   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (bus.sample_valid) begin
                            r_v     <= bus.v_in;
                            r_i     <= bus.i_in;
                            r_req   <= 1'b0;
                            r_state <= S_COMPUTE;
                        end
                    end
                    S_COMPUTE: begin
                        r_power  <= w_prod;
                        r_p_prev <= w_prod;
                        r_first  <= 1'b0;
                        if (!r_first && (w_prod < r_p_prev)) begin
                            r_dir <= ~r_dir;
                        end
                        r_state  <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        r_duty  <= w_duty_next[DUTY_W-1:0];
                        r_upd   <= (w_duty_next != {1'b0, r_duty});
                        if (w_at_limit) begin
                            r_dir <= ~r_dir;
                        end
                        r_state <= S_SETTLE;
                        r_cnt   <= c_settle_ld;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sample_req  = r_req;
    assign bus.duty        = r_duty;
    assign bus.duty_update = r_upd;
    assign bus.dir         = r_dir;
    assign bus.power       = r_power;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mppt_po_controller.sv
// ============================================================================
// Module   : tb_mppt_po_controller
// Brief    : Scoreboard bench for the P&O tracker (nominal and clamp instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mppt_po_controller;

    localparam int SETTLE = 4;
    localparam int STEP   = 4;
    localparam int DMIN   = 16;
    localparam int DMAX   = 240;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cur;

    typedef struct {
        int         dut;
        logic [15:0] power;
        logic [7:0]  duty;
        logic        dir;
        logic        upd;
    } exp_t;

    exp_t sb[$];
    int   m_duty[2];
    int   m_dir[2];
    int   m_pprev[2];
    int   m_first[2];

    mppt_po_controller_if #(.DUTY_W(8)) bus_a ();
    mppt_po_controller_if #(.DUTY_W(8)) bus_b ();

    mppt_po_controller #(
        .DUTY_W(8), .STEP(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
        .DUTY_INIT(128), .SETTLE_CYCLES(SETTLE)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master)
    );

    mppt_po_controller #(
        .DUTY_W(8), .STEP(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
        .DUTY_INIT(236), .SETTLE_CYCLES(SETTLE)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master)
    );

    logic        obs_req;
    logic        obs_busy;
    logic        obs_dir;
    logic        obs_upd;
    logic [7:0]  obs_duty;
    logic [15:0] obs_power;

    assign obs_req   = (cur == 1) ? bus_b.sample_req  : bus_a.sample_req;
    assign obs_busy  = (cur == 1) ? bus_b.busy        : bus_a.busy;
    assign obs_dir   = (cur == 1) ? bus_b.dir         : bus_a.dir;
    assign obs_upd   = (cur == 1) ? bus_b.duty_update : bus_a.duty_update;
    assign obs_duty  = (cur == 1) ? bus_b.duty        : bus_a.duty;
    assign obs_power = (cur == 1) ? bus_b.power       : bus_a.power;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_duty  = '{128, 236};
        m_dir   = '{1, 1};
        m_pprev = '{0, 0};
        m_first = '{1, 1};
    endtask

    // Behavioural P&O reference: push expected outcome when the sample is driven
    task automatic model_push(input int s, input int v, input int i);
        exp_t e;
        int   p;
        int   nd;
        p = v * i;
        if (m_first[s] == 0 && p < m_pprev[s]) m_dir[s] = 1 - m_dir[s];
        m_pprev[s] = p;
        m_first[s] = 0;
        if (m_dir[s] == 1) begin
            nd = m_duty[s] + STEP;
            if (nd >= DMAX) begin nd = DMAX; m_dir[s] = 0; end
        end else begin
            nd = m_duty[s] - STEP;
            if (nd <= DMIN) begin nd = DMIN; m_dir[s] = 1; end
        end
        e.dut   = s;
        e.power = p[15:0];
        e.duty  = nd[7:0];
        e.dir   = m_dir[s][0];
        e.upd   = (nd != m_duty[s]);
        m_duty[s] = nd;
        sb.push_back(e);
    endtask

    task automatic set_valid(input int s, input logic val);
        if (s == 1) bus_b.sample_valid = val;
        else        bus_a.sample_valid = val;
    endtask

    task automatic do_sample(input int s, input int v, input int i);
        exp_t e;
        int   k;
        cur = s;
        k = 0;
        while (!obs_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (obs_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout dut=%0d got=%b want=1", s, obs_req);
            return;
        end
        model_push(s, v, i);
        bus_a.v_in = v[7:0]; bus_b.v_in = v[7:0];
        bus_a.i_in = i[7:0]; bus_b.i_in = i[7:0];
        set_valid(s, 1'b1);
        @(negedge clk);
        set_valid(s, 1'b0);
        checks++;
        if (obs_req !== 1'b0) begin
            errors++;
            $display("FAIL req_drop dut=%0d got=%b want=0", s, obs_req);
        end
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty dut=%0d", s);
            return;
        end
        e = sb.pop_front();
        if (obs_power !== e.power) begin
            errors++;
            $display("FAIL power dut=%0d got=%0d want=%0d", s, obs_power, e.power);
        end
        @(negedge clk);
        checks++;
        if (obs_duty !== e.duty || obs_dir !== e.dir || obs_upd !== e.upd) begin
            errors++;
            $display("FAIL update dut=%0d got duty=%0d dir=%b upd=%b want duty=%0d dir=%b upd=%b",
                     s, obs_duty, obs_dir, obs_upd, e.duty, e.dir, e.upd);
        end
        @(negedge clk);
        checks++;
        if (obs_upd !== 1'b0) begin
            errors++;
            $display("FAIL upd_pulse_width dut=%0d got=%b want=0", s, obs_upd);
        end
    endtask

    task automatic test_reset();
        int rise;
        cur = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_duty !== 8'd128 || obs_dir !== 1'b1 || obs_req !== 1'b0 ||
            obs_busy !== 1'b0 || obs_upd !== 1'b0 || obs_power !== 16'd0) begin
            errors++;
            $display("FAIL reset_a got duty=%0d dir=%b req=%b busy=%b upd=%b pwr=%0d want 128/1/0/0/0/0",
                     obs_duty, obs_dir, obs_req, obs_busy, obs_upd, obs_power);
        end
        checks++;
        if (bus_b.duty !== 8'd236) begin
            errors++;
            $display("FAIL reset_b_duty got=%0d want=236", bus_b.duty);
        end
        rst = 1'b0;
        @(negedge clk);
        bus_a.en = 1'b1;
        rise = 0;
        for (int n = 1; n <= 8 && rise == 0; n++) begin
            @(negedge clk);
            if (obs_req) rise = n;
            if (n == 1) begin
                checks++;
                if (obs_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_en got=%b want=1", obs_busy);
                end
            end
        end
        checks++;
        if (rise - 1 != SETTLE) begin
            errors++;
            $display("FAIL req_latency got=%0d edges want=%0d", rise - 1, SETTLE);
        end
    endtask

    task automatic test_first_sample();
        do_sample(0, 100, 50);
        checks++;
        if (obs_duty !== 8'd132 || obs_dir !== 1'b1) begin
            errors++;
            $display("FAIL first_sample got duty=%0d dir=%b want 132/1", obs_duty, obs_dir);
        end
    endtask

    task automatic test_tracking();
        do_sample(0, 100, 60);
        do_sample(0, 100, 40);
        do_sample(0, 100, 40);
        checks++;
        if (obs_duty !== 8'd128 || obs_dir !== 1'b0) begin
            errors++;
            $display("FAIL tracking_end got duty=%0d dir=%b want 128/0", obs_duty, obs_dir);
        end
    endtask

    task automatic test_abort();
        int k;
        cur = 0;
        k = 0;
        while (!obs_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        bus_a.en = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_req !== 1'b0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort got req=%b busy=%b want 0/0", obs_req, obs_busy);
        end
        bus_a.v_in = 8'd200; bus_a.i_in = 8'd200;
        bus_a.sample_valid = 1'b1;
        @(negedge clk);
        bus_a.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_duty !== 8'd128 || obs_upd !== 1'b0 || obs_power !== 16'd4000 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_valid got duty=%0d upd=%b pwr=%0d busy=%b want 128/0/4000/0",
                     obs_duty, obs_upd, obs_power, obs_busy);
        end
        m_first[0] = 1;
        bus_a.en = 1'b1;
        do_sample(0, 10, 10);
        checks++;
        if (obs_duty !== 8'd124 || obs_dir !== 1'b0) begin
            errors++;
            $display("FAIL reenable_first got duty=%0d dir=%b want 124/0", obs_duty, obs_dir);
        end
    endtask

    task automatic test_clamp();
        cur = 1;
        bus_b.en = 1'b1;
        do_sample(1, 100, 50);
        checks++;
        if (obs_duty !== 8'd240 || obs_dir !== 1'b0) begin
            errors++;
            $display("FAIL clamp_hit got duty=%0d dir=%b want 240/0", obs_duty, obs_dir);
        end
        do_sample(1, 10, 10);
        checks++;
        if (obs_duty !== 8'd240 || obs_dir !== 1'b0) begin
            errors++;
            $display("FAIL clamp_hold got duty=%0d dir=%b want 240/0", obs_duty, obs_dir);
        end
        bus_b.en = 1'b0;
        cur = 0;
    endtask

    task automatic test_async_reset();
        cur = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_sample(0, 10, 10);
        do_sample(0, 10, 20);
        do_sample(0, 10, 30);
        do_sample(0, 10, 40);
        checks++;
        if (obs_duty !== 8'd144 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got duty=%0d busy=%b want 144/1", obs_duty, obs_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_duty !== 8'd128 || obs_busy !== 1'b0 || obs_upd !== 1'b0 ||
            obs_req !== 1'b0 || obs_dir !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got duty=%0d busy=%b upd=%b req=%b dir=%b want 128/0/0/0/1",
                     obs_duty, obs_busy, obs_upd, obs_req, obs_dir);
        end
        bus_a.en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_busy !== 1'b0 || obs_duty !== 8'd128 || obs_upd !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got busy=%b duty=%0d upd=%b want 0/128/0",
                     obs_busy, obs_duty, obs_upd);
        end
    endtask

    initial begin
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        cur    = 0;
        bus_a.en = 1'b0; bus_a.sample_valid = 1'b0; bus_a.v_in = '0; bus_a.i_in = '0;
        bus_b.en = 1'b0; bus_b.sample_valid = 1'b0; bus_b.v_in = '0; bus_b.i_in = '0;
        model_reset();
        test_reset();
        test_first_sample();
        test_tracking();
        test_abort();
        test_clamp();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
